// File: rtl/tick_timer_pkg.sv
// Shared encodings and defaults for the tick timer.
// The FSM state is 2 bits wide; encoding 3 is unused and recovers to IDLE.
package tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic PERIODIC = 1'b0;
    localparam logic ONESHOT  = 1'b1;

    localparam int DEFAULT_PERIOD = 50000;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter with clear, load, hold and a zero flag.
// Decrement saturates at zero; the owner treats zero as terminal count.
module tick_down_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 zero
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    // clear beats load beats decrement; no request means hold
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - ONE;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/tick_timer_gen.sv
// Programmable period timer: periodic or one-shot single-cycle tick with
// run-time period load, pause via enable, abort and remaining-count output.
module tick_timer_gen
    import tick_timer_pkg::*;
#(
    parameter int CNT_WIDTH      = 16,
    parameter int DEFAULT_PERIOD = tick_timer_pkg::DEFAULT_PERIOD
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] period_in,
    input  logic                 abort,
    output logic                 tick,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] count,
    output logic [1:0]           fsm_state
);

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DEFAULT_P = CNT_WIDTH'(DEFAULT_PERIOD);

    state_t                 state;
    state_t                 state_next;
    logic                   mode_q;
    logic                   mode_capture;
    logic [CNT_WIDTH-1:0]   period_q;
    logic [CNT_WIDTH-1:0]   period_eff;
    logic [CNT_WIDTH-1:0]   reload_value;
    logic                   tick_next;
    logic                   cnt_clear;
    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   cnt_zero;

    // A load in the same cycle as a start or reload wins over the stored period.
    always_comb begin
        period_eff = period_q;
        if (load) begin
            period_eff = (period_in == '0) ? ONE : period_in;
        end
    end

    assign reload_value = period_eff - ONE;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            period_q <= DEFAULT_P;
        end else if (load) begin
            period_q <= period_eff;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tick   <= 1'b0;
            mode_q <= PERIODIC;
        end else begin
            state <= state_next;
            tick  <= tick_next;
            if (mode_capture) begin
                mode_q <= mode;
            end
        end
    end

    always_comb begin
        state_next   = state;
        tick_next    = 1'b0;
        mode_capture = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !abort) begin
                    state_next   = COUNT;
                    mode_capture = 1'b1;
                    cnt_load     = 1'b1;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                end else if (enable) begin
                    if (cnt_zero) begin
                        tick_next = 1'b1;
                        if (mode_q == ONESHOT) begin
                            state_next = DONE;
                        end else begin
                            cnt_load = 1'b1;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            DONE: begin
                // a held-high enable must be released before the next start
                if (!enable || abort) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    tick_down_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clock      (clock),
        .rst        (rst),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (reload_value),
        .dec        (cnt_dec),
        .value      (count),
        .zero       (cnt_zero)
    );

    assign busy      = (state == COUNT);
    assign fsm_state = state;

endmodule

// File: tb/tb_tick_timer_gen.sv
// Self-checking bench for tick_timer_gen: directed scenarios plus random
// stimulus, all checked each cycle against a behavioural timer model.
module tb_tick_timer_gen;

    localparam int W     = 16;
    localparam int DEF_P = 50000;

    logic           clock = 1'b0;
    logic           rst;
    logic           enable;
    logic           mode;
    logic           load;
    logic [W-1:0]   period_in;
    logic           abort;
    logic           tick;
    logic           busy;
    logic [W-1:0]   count;
    logic [1:0]     fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model: phase 0 idle, 1 running, 2 finished one-shot
    int  m_phase;
    int  m_left;
    int  m_p;
    bit  m_oneshot;
    bit  m_tick;

    always #5 clock = ~clock;

    tick_timer_gen #(
        .CNT_WIDTH      (W),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .load      (load),
        .period_in (period_in),
        .abort     (abort),
        .tick      (tick),
        .busy      (busy),
        .count     (count),
        .fsm_state (fsm_state)
    );

    function automatic void model_reset();
        m_phase   = 0;
        m_left    = 0;
        m_p       = DEF_P;
        m_oneshot = 1'b0;
        m_tick    = 1'b0;
    endfunction

    function automatic void model_edge();
        int p_new;
        p_new  = load ? ((int'(period_in) == 0) ? 1 : int'(period_in)) : m_p;
        m_tick = 1'b0;
        if (m_phase == 0) begin
            if (enable && !abort) begin
                m_phase   = 1;
                m_oneshot = mode;
                m_left    = p_new - 1;
            end
        end else if (m_phase == 1) begin
            if (abort) begin
                m_phase = 0;
                m_left  = 0;
            end else if (enable) begin
                if (m_left == 0) begin
                    m_tick = 1'b1;
                    if (m_oneshot) m_phase = 2;
                    else m_left = p_new - 1;
                end else begin
                    m_left = m_left - 1;
                end
            end
        end else begin
            if (!enable || abort) m_phase = 0;
        end
        m_p = p_new;
    endfunction

    function automatic logic [W+1:0] model_obs();
        return {m_tick, (m_phase == 1), W'(m_left)};
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        enable    = 1'b0;
        mode      = 1'b0;
        load      = 1'b0;
        period_in = '0;
        abort     = 1'b0;
    endtask

    task automatic go_idle();
        idle_inputs();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        vectors++;
        if ({tick, busy, count} !== model_obs() || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL go_idle: got %b/%b/%0d want %b/0/%0d", tick, busy, count, m_tick, m_left);
        end
    endtask

    task automatic load_period(input int p);
        load      = 1'b1;
        period_in = W'(p);
        step();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if ({tick, busy, count} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got %b/%b/%0d want 0/0/0", tick, busy, count);
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({tick, busy, count} !== model_obs() || fsm_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_release: got %b/%b/%0d st %0d want 0/0/0 st 0", tick, busy, count, fsm_state);
        end
    endtask

    task automatic test_default_period();
        int first_tick;
        int ticks;
        first_tick = -1;
        ticks      = 0;
        enable = 1'b1;
        mode   = 1'b0;
        step();
        vectors++;
        if (count !== W'(DEF_P - 1) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL default_start: got count %0d busy %b want %0d 1", count, busy, DEF_P - 1);
        end
        for (int t = 1; t <= DEF_P; t++) begin
            step();
            vectors++;
            if ({tick, busy, count} !== model_obs()) begin
                miscompares++;
                $display("FAIL default_cycle t=%0d: got %b/%b/%0d want %b/%b/%0d",
                         t, tick, busy, count, m_tick, m_phase == 1, m_left);
            end
            if (tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = t;
            end
        end
        vectors++;
        if (first_tick != DEF_P || ticks != 1) begin
            miscompares++;
            $display("FAIL default_first_tick: got t=%0d n=%0d want t=%0d n=1", first_tick, ticks, DEF_P);
        end
        go_idle();
    endtask

    task automatic test_pause();
        int tick_at[$];
        load_period(4);
        mode = 1'b0;
        for (int t = 0; t <= 16; t++) begin
            enable = !(t >= 7 && t <= 9);
            step();
            vectors++;
            if ({tick, busy, count} !== model_obs()) begin
                miscompares++;
                $display("FAIL pause_cycle t=%0d: got %b/%b/%0d want %b/%b/%0d",
                         t, tick, busy, count, m_tick, m_phase == 1, m_left);
            end
            if (t >= 7 && t <= 9) begin
                vectors++;
                if (count !== W'(1) || tick !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pause_hold t=%0d: got count %0d tick %b want 1 0", t, count, tick);
                end
            end
            if (tick === 1'b1) tick_at.push_back(t);
        end
        vectors++;
        if (tick_at.size() != 3 || tick_at[0] != 4 || tick_at[1] != 11 || tick_at[2] != 15) begin
            miscompares++;
            $display("FAIL pause_ticks: got %0d ticks %p want 4 11 15", tick_at.size(), tick_at);
        end
        go_idle();
    endtask

    task automatic test_oneshot();
        int tick_at[$];
        load_period(3);
        mode   = 1'b1;
        enable = 1'b1;
        for (int t = 0; t <= 8; t++) begin
            step();
            vectors++;
            if ({tick, busy, count} !== model_obs()) begin
                miscompares++;
                $display("FAIL oneshot_cycle t=%0d: got %b/%b/%0d want %b/%b/%0d",
                         t, tick, busy, count, m_tick, m_phase == 1, m_left);
            end
            if (tick === 1'b1) tick_at.push_back(t);
        end
        vectors++;
        if (tick_at.size() != 1 || tick_at[0] != 3 || busy !== 1'b0 || fsm_state !== 2'd2) begin
            miscompares++;
            $display("FAIL oneshot_single: got %0d ticks busy %b st %0d want 1 tick at 3 busy 0 st 2",
                     tick_at.size(), busy, fsm_state);
        end
        enable = 1'b0;
        step();
        tick_at.delete();
        enable = 1'b1;
        for (int t = 0; t <= 5; t++) begin
            step();
            vectors++;
            if ({tick, busy, count} !== model_obs()) begin
                miscompares++;
                $display("FAIL oneshot_restart t=%0d: got %b/%b/%0d want %b/%b/%0d",
                         t, tick, busy, count, m_tick, m_phase == 1, m_left);
            end
            if (tick === 1'b1) tick_at.push_back(t);
        end
        vectors++;
        if (tick_at.size() != 1 || tick_at[0] != 3) begin
            miscompares++;
            $display("FAIL oneshot_retick: got %0d ticks %p want 1 at 3", tick_at.size(), tick_at);
        end
        go_idle();
    endtask

    task automatic test_load_edges();
        int tick_at[$];
        int n;
        load      = 1'b1;
        period_in = '0;
        enable    = 1'b1;
        mode      = 1'b0;
        n         = 0;
        for (int t = 0; t <= 5; t++) begin
            step();
            load = 1'b0;
            vectors++;
            if ({tick, busy, count} !== model_obs() || tick !== (t >= 1)) begin
                miscompares++;
                $display("FAIL load_zero t=%0d: got %b/%b/%0d want %b/1/0", t, tick, busy, count, t >= 1);
            end
        end
        go_idle();
        load_period(4);
        enable = 1'b1;
        for (int t = 0; t <= 13; t++) begin
            if (t == 2) begin
                load      = 1'b1;
                period_in = W'(8);
            end
            step();
            load = 1'b0;
            vectors++;
            if ({tick, busy, count} !== model_obs()) begin
                miscompares++;
                $display("FAIL load_run t=%0d: got %b/%b/%0d want %b/%b/%0d",
                         t, tick, busy, count, m_tick, m_phase == 1, m_left);
            end
            if (tick === 1'b1) tick_at.push_back(t);
        end
        n = tick_at.size();
        vectors++;
        if (n != 2 || tick_at[0] != 4 || tick_at[1] != 12) begin
            miscompares++;
            $display("FAIL load_run_ticks: got %0d ticks %p want 4 12", n, tick_at);
        end
        go_idle();
    endtask

    task automatic test_abort_terminal();
        int ticks;
        ticks = 0;
        load_period(5);
        enable = 1'b1;
        mode   = 1'b0;
        for (int t = 0; t <= 5; t++) begin
            abort = (t == 5);
            step();
            vectors++;
            if ({tick, busy, count} !== model_obs()) begin
                miscompares++;
                $display("FAIL abort_cycle t=%0d: got %b/%b/%0d want %b/%b/%0d",
                         t, tick, busy, count, m_tick, m_phase == 1, m_left);
            end
            if (tick === 1'b1) ticks++;
        end
        vectors++;
        if (ticks != 0 || tick !== 1'b0 || busy !== 1'b0 || count !== '0 || fsm_state !== 2'd0) begin
            miscompares++;
            $display("FAIL abort_terminal: got ticks %0d %b/%b/%0d st %0d want 0 0/0/0 st 0",
                     ticks, tick, busy, count, fsm_state);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        load_period(5);
        enable = 1'b1;
        mode   = 1'b0;
        repeat (3) step();
        vectors++;
        if (count !== W'(2) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_setup: got count %0d busy %b want 2 1", count, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if ({tick, busy, count} !== '0) begin
            miscompares++;
            $display("FAIL areset_async: got %b/%b/%0d want 0/0/0", tick, busy, count);
        end
        #1;
        rst = 1'b0;
        step();
        vectors++;
        if (count !== W'(DEF_P - 1) || busy !== 1'b1 || {tick, busy, count} !== model_obs()) begin
            miscompares++;
            $display("FAIL areset_period: got count %0d busy %b want %0d 1", count, busy, DEF_P - 1);
        end
        go_idle();
    endtask

    task automatic test_random();
        load_period(3);
        for (int t = 0; t < 400; t++) begin
            enable    = ($urandom_range(0, 99) < 85);
            mode      = 1'($urandom_range(0, 1));
            load      = ($urandom_range(0, 99) < 8);
            period_in = W'($urandom_range(0, 6));
            abort     = ($urandom_range(0, 99) < 3);
            step();
            vectors++;
            if ({tick, busy, count} !== model_obs()) begin
                miscompares++;
                $display("FAIL random t=%0d: got %b/%b/%0d want %b/%b/%0d",
                         t, tick, busy, count, m_tick, m_phase == 1, m_left);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_pause();
        test_oneshot();
        test_load_edges();
        test_abort_terminal();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_timer_gen.md
# tick_timer_gen

Parametrised, programmable period timer for the LCD controller's delay and strobe sequencing. It generates a single-cycle `tick` every `period` clock cycles in periodic mode, or one `tick` per start in one-shot mode. It adds a run-time loadable period, pause/resume, abort and remaining-count visibility. The LCD command sequencer uses it as its time base for power-up waits, enable-pulse widths and busy-wait intervals.

## Interface
- `CNT_WIDTH`, 16: width of the period register and down-counter.
- `DEFAULT_PERIOD`, 50000: period loaded at reset (1 ms at 50 MHz).

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  start (in IDLE) / run-not-pause (in COUNT).
- `mode`  in  1  0 = periodic, 1 = one-shot; sampled at start.
- `load`  in  1  single-cycle strobe: capture `period_in` into the period register.
- `period_in`  in  CNT_WIDTH  new period in cycles; 0 is treated as 1.
- `abort`  in  1  return to IDLE immediately.
- `tick`  out  1  registered one-cycle pulse at terminal count.
- `busy`  out  1  high while in COUNT, including when paused.
- `count`  out  CNT_WIDTH  remaining cycles before the next tick.

## Operation
- Period register `P`:
  - Reset value is `DEFAULT_PERIOD`.
  - `load` writes it in any state, from `max(period_in, 1)`.
  - A new value takes effect at the next start or periodic reload. A counter already running is not modified.
- Start latch: `mode` is latched into `mode_q` on the IDLE->COUNT transition.
- States:
  - IDLE
    - `count` = 0, `tick` = 0.
    - If `enable` = 1 and `abort` = 0: go to COUNT, `count` <= P-1.
    - If `load` and start occur in the same cycle, `count` <= `max(period_in,1)`-1, so the new value wins.
  - COUNT
    - `abort` = 1: go to IDLE, `count` <= 0, no tick. Abort has priority over everything.
    - `enable` = 0: hold `count` (pause), no tick.
    - `enable` = 1 and `count` != 0: decrement `count`.
    - `enable` = 1 and `count` = 0: `tick` <= 1. If `mode_q` = 0, reload `count` <= P-1 and stay in COUNT. If `mode_q` = 1, go to DONE.
  - DONE
    - `tick` = 0, `count` = 0.
    - Go to IDLE when `enable` = 0 or `abort` = 1. A held-high `enable` does not retrigger.
- Illegal state encoding: go to IDLE.
- Arithmetic is unsigned, CNT_WIDTH bits. The decrement never wraps because 0 is the terminal check.

## Timing
- Reset values: state IDLE, `tick` 0, `busy` 0, `count` 0, P = `DEFAULT_PERIOD`, `mode_q` 0.
- Start latency: `enable` sampled high at edge 0 gives `busy` = 1 and `count` = P-1 after edge 0.
- First `tick` is high for exactly one cycle after edge P.
- Periodic mode: ticks are exactly P cycles apart while `enable` is held.
- Each paused cycle delays the next tick by one cycle.
- P = 1 in periodic mode: `tick` is high every cycle after the first edge.
- `abort` sampled at the edge where `count` = 0: no tick. `tick` and `busy` are low after that edge.
- `rst` asserted mid-count: all outputs go to reset values asynchronously. The previously loaded P is lost.

## Structure
- Package `tick_timer_pkg`:
  - state encoding constants IDLE/COUNT/DONE (2-bit);
  - mode constants PERIODIC/ONESHOT;
  - default `DEFAULT_PERIOD`.
- One natural sub-module: `tick_down_counter`, a loadable CNT_WIDTH down-counter with load, hold and zero flag. The FSM and period register stay in `tick_timer_gen`.

## Test plan
- Reset with CNT_WIDTH=16 and default period:
  - stimulus: `enable` high, periodic;
  - required: first tick 50000 cycles after start, second tick 50000 cycles later, `busy` stays 1.
- Periodic with pause:
  - stimulus: load 4, periodic, start, then drop `enable` for 3 cycles after 2 counts;
  - required: ticks at cycles 4, 11 and 15 relative to start, and `count` holds 1 while paused.
- One-shot:
  - stimulus: load 3, `mode` = 1, `enable` held high;
  - required: single tick at cycle 3, then DONE with `busy` = 0 and no further ticks;
  - then drop `enable` 1 cycle, raise it again: new tick 3 cycles after the restart.
- Load edge cases:
  - stimulus: `load` with `period_in` = 0 together with start;
  - required: tick every cycle from cycle 1;
  - stimulus: load 8 while running with P = 4;
  - required: the current interval still ends at 4, the next interval is 8.
- Abort at terminal count:
  - stimulus: P = 5, `abort` pulsed at the edge where `count` = 0;
  - required: no tick, IDLE, `count` = 0.
- Async reset mid-count:
  - stimulus: assert `rst` between clock edges with `count` = 2;
  - required: outputs zero before the next edge, and P returns to 50000.
